shift_add_multiplier8_ctrl: RTL

//  Sequential 8x8 unsigned shift-and-add multiplier control/datapath stage.

---
 rtl/shift_add_multiplier8_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/shift_add_multiplier8_ctrl.sv
// Sequential WIDTHxWIDTH unsigned shift-and-add multiplier controller.
// Ports: clk_i/rst_i (sync, active-high); start_i + operands in;
//   add1_o/add2_o to an external adder, sum_i back from it;
//   busy_o, done_o (1-cycle pulse), product_o held until next start.
module shift_add_multiplier8_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ADD_WIDTH = 2*WIDTH-1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic [ADD_WIDTH-1:0] add1_o,
  output logic [ADD_WIDTH-1:0] add2_o,
  input  logic [ADD_WIDTH:0]   sum_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [ADD_WIDTH-1:0] a_ext;
  logic [ADD_WIDTH-1:0] pp;

  assign a_ext = {{(ADD_WIDTH-WIDTH){1'b0}}, a_q};

  // Partial product for the current bit; forced to zero outside
  // ACCUM so the adder inputs stay quiet.
  always_comb begin
    pp = '0;
    if (state_q == ACCUM && b_q[count_q]) begin
      pp = a_ext << count_q;
    end
  end

  // acc stays below 2^ADD_WIDTH until the final step, so
  // dropping its top bit here loses nothing.
  assign add1_o = (state_q == ACCUM) ? acc_q[ADD_WIDTH-1:0] : '0;
  assign add2_o = pp;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = multiplicand_i;
          b_d     = multiplier_i;
          acc_d   = '0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = sum_i;
        if (count_q == CW'(WIDTH-1)) begin
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        product_d = acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == ACCUM) || (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule
